// File: rtl/snn_pool1d_stream.sv
// Event-driven 1D spike pooling: accumulates per (channel, window) counts over a
// frame, then scans the table and streams out pooled spikes.
//
// state   | meaning
// CLEAR   | zero one table entry per cycle after reset
// COLLECT | wait for an input event (tready high)
// UPDATE  | one window-range cycle, then one table entry per covering window
// SCAN    | visit one entry per cycle, test fire condition, clear it
// EMIT    | hold pooled event until downstream accepts
// DONE    | one-cycle frame_done pulse
module snn_pool1d_stream #(
  parameter int INPUT_LENGTH  = 128,
  parameter int CHANNELS      = 32,
  parameter int POOL_SIZE     = 2,
  parameter int STRIDE        = 2,
  parameter int OUTPUT_LENGTH = (INPUT_LENGTH - POOL_SIZE) / STRIDE + 1,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 cfg_mode_i,
  input  logic [CNT_WIDTH-1:0] cfg_threshold_i,
  input  logic                 s_axis_input_tvalid_i,
  input  logic [31:0]          s_axis_input_tdata_i,
  input  logic                 s_axis_input_tlast_i,
  output logic                 s_axis_input_tready_o,
  output logic                 m_axis_output_tvalid_o,
  output logic [31:0]          m_axis_output_tdata_o,
  output logic                 m_axis_output_tlast_o,
  input  logic                 m_axis_output_tready_i,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [15:0]          drop_count_o
);

  localparam int ENTRIES = CHANNELS * OUTPUT_LENGTH;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int O_W     = (OUTPUT_LENGTH > 1) ? $clog2(OUTPUT_LENGTH) : 1;
  localparam int FC_W    = $clog2(ENTRIES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_CLEAR, S_COLLECT, S_UPDATE, S_SCAN, S_EMIT, S_DONE} state_t;

  logic [CNT_WIDTH-1:0] cnt_mem [ENTRIES];
  logic [7:0]           ts_mem  [ENTRIES];

  state_t               state_q;
  logic [IDX_W-1:0]     clr_idx_q;
  logic [15:0]          ev_pos_q;
  logic [7:0]           ev_ch_q;
  logic [7:0]           ev_ts_q;
  logic                 ev_last_q;
  logic                 ev_drop_q;
  logic                 prep_q;
  logic [O_W-1:0]       upd_o_q;
  logic [O_W-1:0]       upd_hi_q;
  logic                 first_q;
  logic [CNT_WIDTH-1:0] thr_eff_q;
  logic [FC_W-1:0]      fire_rem_q;
  logic [IDX_W-1:0]     scan_idx_q;
  logic [7:0]           scan_ch_q;
  logic [O_W-1:0]       scan_o_q;
  logic                 scan_last_q;
  logic                 m_tvalid_q;
  logic [31:0]          m_tdata_q;
  logic                 m_tlast_q;
  logic [15:0]          drop_q;

  int                   win_lo, win_hi;
  logic                 win_empty;
  logic                 in_drop;
  logic [IDX_W-1:0]     upd_addr;
  logic [IDX_W-1:0]     rd_addr;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [7:0]           rd_ts;
  logic [CNT_WIDTH-1:0] new_cnt;
  logic [7:0]           new_ts;
  logic                 fires;
  logic                 crosses;
  logic                 scan_end;

  logic                 mem_we;
  logic [IDX_W-1:0]     mem_addr;
  logic [CNT_WIDTH-1:0] mem_cnt_d;
  logic [7:0]           mem_ts_d;

  assign s_axis_input_tready_o  = enable_i && (state_q == S_COLLECT);
  assign busy_o                 = (state_q != S_COLLECT);
  assign frame_done_o           = (state_q == S_DONE);
  assign m_axis_output_tvalid_o = m_tvalid_q;
  assign m_axis_output_tdata_o  = m_tdata_q;
  assign m_axis_output_tlast_o  = m_tlast_q;
  assign drop_count_o           = drop_q;

  assign in_drop = (32'(s_axis_input_tdata_i[31:16]) >= 32'(INPUT_LENGTH)) ||
                   (32'(s_axis_input_tdata_i[15:8])  >= 32'(CHANNELS));

  // Covering windows are o_lo..o_hi; an empty range is an uncovered tail position.
  always_comb begin
    win_hi = int'(ev_pos_q) / STRIDE;
    if (win_hi > OUTPUT_LENGTH - 1) win_hi = OUTPUT_LENGTH - 1;
    if (int'(ev_pos_q) < POOL_SIZE - 1) win_lo = 0;
    else win_lo = (int'(ev_pos_q) - POOL_SIZE + STRIDE) / STRIDE;
    win_empty = (win_lo > win_hi);
  end

  always_comb begin
    upd_addr = IDX_W'(32'(ev_ch_q) * 32'(OUTPUT_LENGTH) + 32'(upd_o_q));
    rd_addr  = (state_q == S_SCAN) ? scan_idx_q : upd_addr;
    rd_cnt   = cnt_mem[rd_addr];
    rd_ts    = ts_mem[rd_addr];
    new_cnt  = (rd_cnt == CNT_MAX) ? rd_cnt : rd_cnt + CNT_WIDTH'(1);
    new_ts   = (ev_ts_q > rd_ts) ? ev_ts_q : rd_ts;
    fires    = (rd_cnt >= thr_eff_q);
    // Counting threshold crossings during UPDATE gives the exact fire total for tlast.
    crosses  = (rd_cnt < thr_eff_q) && (new_cnt >= thr_eff_q);
    scan_end = (scan_idx_q == IDX_W'(ENTRIES - 1));
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = clr_idx_q;
    mem_cnt_d = '0;
    mem_ts_d  = '0;
    if (enable_i) begin
      case (state_q)
        S_CLEAR: begin
          mem_we   = 1'b1;
          mem_addr = clr_idx_q;
        end
        S_UPDATE: begin
          if (!prep_q) begin
            mem_we    = 1'b1;
            mem_addr  = upd_addr;
            mem_cnt_d = new_cnt;
            mem_ts_d  = new_ts;
          end
        end
        S_SCAN: begin
          mem_we   = 1'b1;
          mem_addr = scan_idx_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      cnt_mem[mem_addr] <= mem_cnt_d;
      ts_mem[mem_addr]  <= mem_ts_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_CLEAR;
      clr_idx_q   <= '0;
      ev_pos_q    <= '0;
      ev_ch_q     <= '0;
      ev_ts_q     <= '0;
      ev_last_q   <= 1'b0;
      ev_drop_q   <= 1'b0;
      prep_q      <= 1'b0;
      upd_o_q     <= '0;
      upd_hi_q    <= '0;
      first_q     <= 1'b1;
      thr_eff_q   <= CNT_WIDTH'(1);
      fire_rem_q  <= '0;
      scan_idx_q  <= '0;
      scan_ch_q   <= '0;
      scan_o_q    <= '0;
      scan_last_q <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      drop_q      <= '0;
    end else if (enable_i) begin
      case (state_q)
        S_CLEAR: begin
          if (clr_idx_q == IDX_W'(ENTRIES - 1)) begin
            clr_idx_q <= '0;
            first_q   <= 1'b1;
            state_q   <= S_COLLECT;
          end else begin
            clr_idx_q <= clr_idx_q + IDX_W'(1);
          end
        end
        S_COLLECT: begin
          if (s_axis_input_tvalid_i) begin
            ev_pos_q  <= s_axis_input_tdata_i[31:16];
            ev_ch_q   <= s_axis_input_tdata_i[15:8];
            ev_ts_q   <= s_axis_input_tdata_i[7:0];
            ev_last_q <= s_axis_input_tlast_i;
            ev_drop_q <= in_drop;
            if (in_drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (first_q) begin
              if (!cfg_mode_i || cfg_threshold_i == '0) thr_eff_q <= CNT_WIDTH'(1);
              else thr_eff_q <= cfg_threshold_i;
            end
            first_q <= 1'b0;
            prep_q  <= 1'b1;
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (prep_q) begin
            prep_q   <= 1'b0;
            upd_o_q  <= O_W'(win_lo);
            upd_hi_q <= O_W'(win_hi);
            if (ev_drop_q || win_empty) state_q <= ev_last_q ? S_SCAN : S_COLLECT;
          end else begin
            if (crosses) fire_rem_q <= fire_rem_q + FC_W'(1);
            if (upd_o_q == upd_hi_q) state_q <= ev_last_q ? S_SCAN : S_COLLECT;
            else upd_o_q <= upd_o_q + O_W'(1);
          end
        end
        S_SCAN: begin
          scan_last_q <= scan_end;
          if (scan_end) begin
            scan_idx_q <= '0;
            scan_ch_q  <= '0;
            scan_o_q   <= '0;
          end else begin
            scan_idx_q <= scan_idx_q + IDX_W'(1);
            if (scan_o_q == O_W'(OUTPUT_LENGTH - 1)) begin
              scan_o_q  <= '0;
              scan_ch_q <= scan_ch_q + 8'd1;
            end else begin
              scan_o_q <= scan_o_q + O_W'(1);
            end
          end
          if (fires) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= {16'(scan_o_q), scan_ch_q, rd_ts};
            m_tlast_q  <= (fire_rem_q == FC_W'(1));
            fire_rem_q <= fire_rem_q - FC_W'(1);
            state_q    <= S_EMIT;
          end else if (scan_end) begin
            state_q <= S_DONE;
          end
        end
        S_EMIT: begin
          if (m_axis_output_tready_i) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            state_q    <= scan_last_q ? S_DONE : S_SCAN;
          end
        end
        S_DONE: begin
          first_q <= 1'b1;
          state_q <= S_COLLECT;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

endmodule
